instr_issue_queue: RTL and testbench

INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

---
 rtl/instr_issue_queue.sv | 125 ++++++++++++
 tb/tb_instr_issue_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// Dual-issue instruction queue between fetch and decode.
// Optional stall counter: define IQ_PERF_COUNTER_EN.
module instr_issue_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [DATA_WIDTH-1:0]   InstrA,
  input  logic [DATA_WIDTH-1:0]   InstrB,
  input  logic                    FetchValid,
  output logic                    PCSrc,
  output logic                    IncrSrc,
  input  logic [1:0]              DecTake,
  output logic [DATA_WIDTH-1:0]   IssueA,
  output logic [DATA_WIDTH-1:0]   IssueB,
  output logic                    IssueValidA,
  output logic                    IssueValidB,
  output logic [$clog2(DEPTH):0]  Count,
  output logic [31:0]             StallCycles
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE  = CW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  logic          w_full;
  logic          w_one;
  logic [1:0]    w_push;
  logic [1:0]    w_take;
  logic [1:0]    w_pop;
  logic [CW-1:0] w_cnt_nxt;
  logic [AW-1:0] w_tail1;
  logic [AW-1:0] w_head1;

  assign w_full  = (r_count == C_FULL);
  assign w_one   = (r_count == C_ONE);
  assign w_tail1 = r_tail + AW'(1);
  assign w_head1 = r_head + AW'(1);

  // Fetch control depends only on registered
  // Count and flush, never on DecTake.
  always_comb begin
    w_push  = 2'd0;
    PCSrc   = 1'b0;
    IncrSrc = 1'b1;
    unique case (1'b1)
      flush: begin
        w_push = 2'd0;
      end
      (!flush && w_full): begin
        PCSrc   = 1'b1;
        IncrSrc = 1'b0;
      end
      (!flush && w_one): begin
        IncrSrc = 1'b0;
        w_push  = FetchValid ? 2'd1 : 2'd0;
      end
      (!flush && !w_full && !w_one): begin
        w_push = FetchValid ? 2'd2 : 2'd0;
      end
      default: w_push = 2'd0;
    endcase
  end

  always_comb begin
    w_take = (DecTake == 2'd3) ? 2'd2 : DecTake;
    w_pop  = 2'd0;
    if (!flush) begin
      // Count below the request means Count is 0 or 1.
      w_pop = (r_count < CW'(w_take)) ? r_count[1:0]
                                      : w_take;
    end
    w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_pop);
      r_tail  <= r_tail + AW'(w_push);
      r_count <= w_cnt_nxt;
    end
  end

  // Storage is not reset; validity lives in r_count.
  always_ff @(posedge clk) begin
    if (!rst && w_push != 2'd0)
      r_mem[r_tail] <= InstrA;
    if (!rst && w_push == 2'd2)
      r_mem[w_tail1] <= InstrB;
  end

  assign IssueA      = r_mem[r_head];
  assign IssueB      = r_mem[w_head1];
  assign IssueValidA = (r_count != '0);
  assign IssueValidB = (r_count >= CW'(2));
  assign Count       = r_count;

`ifdef IQ_PERF_COUNTER_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk) begin
    if (rst)
      r_stall <= '0;
    else if (PCSrc && r_stall != 32'hFFFF_FFFF)
      r_stall <= r_stall + 32'd1;
  end

  assign StallCycles = r_stall;
`else
  assign StallCycles = 32'd0;
`endif

endmodule

// File: tb/tb_instr_issue_queue.sv
// Self-checking bench for instr_issue_queue.
// Vector table plus instruction scoreboard queue.
module tb_instr_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] InstrA;
  logic [31:0] InstrB;
  logic        FetchValid;
  logic        PCSrc;
  logic        IncrSrc;
  logic [1:0]  DecTake;
  logic [31:0] IssueA;
  logic [31:0] IssueB;
  logic        IssueValidA;
  logic        IssueValidB;
  logic [3:0]  Count;
  logic [31:0] StallCycles;

  instr_issue_queue #(
    .DATA_WIDTH(32),
    .DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .InstrA(InstrA),
    .InstrB(InstrB),
    .FetchValid(FetchValid),
    .PCSrc(PCSrc),
    .IncrSrc(IncrSrc),
    .DecTake(DecTake),
    .IssueA(IssueA),
    .IssueB(IssueB),
    .IssueValidA(IssueValidA),
    .IssueValidB(IssueValidB),
    .Count(Count),
    .StallCycles(StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       fv;
    logic [1:0] take;
    logic       pc;
    logic       inc;
    int         cnt;
  } vec_t;

  vec_t        tbl [22];
  logic [31:0] sb [$];
  int          stall_m;
  int          checks;
  int          failures;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic setv(int i, logic r, logic f,
                      logic v, logic [1:0] t,
                      logic p, logic n, int c);
    tbl[i].rst   = r;
    tbl[i].flush = f;
    tbl[i].fv    = v;
    tbl[i].take  = t;
    tbl[i].pc    = p;
    tbl[i].inc   = n;
    tbl[i].cnt   = c;
  endtask

  function automatic logic [31:0] exp_stall();
`ifdef IQ_PERF_COUNTER_EN
    return stall_m;
`else
    return 32'd0;
`endif
  endfunction

  // Compare visible queue state against the scoreboard.
  task automatic chk_state(string tag);
    int n;
    n = sb.size();
    chk({tag, " Count"}, 32'(Count), 32'(n));
    chk({tag, " ValidA"}, 32'(IssueValidA),
        32'(n >= 1));
    chk({tag, " ValidB"}, 32'(IssueValidB),
        32'(n >= 2));
    if (n >= 1) chk({tag, " IssueA"}, IssueA, sb[0]);
    if (n >= 2) chk({tag, " IssueB"}, IssueB, sb[1]);
    chk({tag, " Stall"}, StallCycles, exp_stall());
  endtask

  task automatic model_step(logic [31:0] a,
                            logic [31:0] b);
    int n;
    int tk;
    int pop;
    n = sb.size();
    if (rst) begin
      sb.delete();
      stall_m = 0;
      return;
    end
    if (n == 8 && !flush) stall_m++;
    if (flush) begin
      sb.delete();
      return;
    end
    tk  = (DecTake == 2'd3) ? 2 : int'(DecTake);
    pop = (tk < n) ? tk : n;
    for (int k = 0; k < pop; k++) void'(sb.pop_front());
    if (FetchValid) begin
      if (n <= 6) begin
        sb.push_back(a);
        sb.push_back(b);
      end else if (n == 7) begin
        sb.push_back(a);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    checks   = 0;
    failures = 0;
    stall_m  = 0;

    //      rst f  fv take pc inc cnt
    setv( 0, 0, 0, 1, 0, 0, 1, 2);
    setv( 1, 0, 0, 1, 0, 0, 1, 4);
    setv( 2, 0, 0, 1, 0, 0, 1, 6);
    setv( 3, 0, 0, 1, 0, 0, 1, 8);
    setv( 4, 0, 0, 1, 0, 1, 0, 8);
    setv( 5, 0, 0, 0, 0, 1, 0, 8);
    setv( 6, 0, 0, 1, 2, 1, 0, 6);
    setv( 7, 0, 0, 1, 0, 0, 1, 8);
    setv( 8, 0, 0, 0, 1, 1, 0, 7);
    setv( 9, 0, 0, 1, 0, 0, 0, 8);
    setv(10, 0, 0, 1, 3, 1, 0, 6);
    setv(11, 0, 0, 0, 2, 0, 1, 4);
    setv(12, 0, 0, 1, 1, 0, 1, 5);
    setv(13, 0, 1, 1, 2, 0, 1, 0);
    setv(14, 0, 0, 1, 0, 0, 1, 2);
    setv(15, 0, 0, 0, 1, 0, 1, 1);
    setv(16, 0, 0, 0, 2, 0, 1, 0);
    setv(17, 0, 0, 0, 2, 0, 1, 0);
    setv(18, 0, 0, 1, 2, 0, 1, 2);
    setv(19, 0, 0, 1, 0, 0, 1, 4);
    setv(20, 1, 0, 1, 2, 0, 1, 0);
    setv(21, 0, 0, 0, 0, 0, 1, 0);

    rst        = 1'b1;
    flush      = 1'b0;
    FetchValid = 1'b0;
    DecTake    = 2'd0;
    InstrA     = '0;
    InstrB     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst Count", 32'(Count), 32'd0);
    chk("rst ValidA", 32'(IssueValidA), 32'd0);
    chk("rst ValidB", 32'(IssueValidB), 32'd0);
    chk("rst PCSrc", 32'(PCSrc), 32'd0);
    chk("rst IncrSrc", 32'(IncrSrc), 32'd1);
    chk("rst Stall", StallCycles, 32'd0);

    for (int i = 0; i < 22; i++) begin
      a = 32'hA000_0000 | 32'(i << 8);
      b = a | 32'h1;
      @(negedge clk);
      rst        = tbl[i].rst;
      flush      = tbl[i].flush;
      FetchValid = tbl[i].fv;
      DecTake    = tbl[i].take;
      InstrA     = a;
      InstrB     = b;
      #1;
      chk($sformatf("v%0d PCSrc", i), 32'(PCSrc),
          32'(tbl[i].pc));
      chk($sformatf("v%0d IncrSrc", i), 32'(IncrSrc),
          32'(tbl[i].inc));
      chk_state($sformatf("v%0d pre", i));
      model_step(a, b);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d CountNext", i), 32'(Count),
          32'(tbl[i].cnt));
    end

    // Reference pair from reset, checked against constants.
    @(negedge clk);
    rst = 1'b1;
    FetchValid = 1'b0;
    DecTake = 2'd0;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stall_m = 0;
    FetchValid = 1'b1;
    InstrA = 32'h0000_0013;
    InstrB = 32'h0010_0093;
    #1;
    chk("pair same-cycle ValidA", 32'(IssueValidA), 32'd0);
    @(negedge clk);
    FetchValid = 1'b0;
    #1;
    chk("pair Count", 32'(Count), 32'd2);
    chk("pair IssueA", IssueA, 32'h0000_0013);
    chk("pair IssueB", IssueB, 32'h0010_0093);
    chk("pair ValidA", 32'(IssueValidA), 32'd1);
    chk("pair ValidB", 32'(IssueValidB), 32'd1);

    // Single pop of one valid entry, take of 2 requested.
    DecTake = 2'd1;
    @(negedge clk);
    DecTake = 2'd2;
    #1;
    chk("drain Count", 32'(Count), 32'd1);
    chk("drain IssueA", IssueA, 32'h0010_0093);
    @(negedge clk);
    DecTake = 2'd0;
    #1;
    chk("underflow Count", 32'(Count), 32'd0);
    chk("underflow ValidA", 32'(IssueValidA), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
